// File: rtl/vm_multi_coin_if.sv
// Coin / vend handshake bundle for the multi-coin vending controller.
// The controller side takes the slave modport; the coin acceptor side
// (or a bench) takes the master modport.
interface vm_multi_coin_if #(
  parameter int CREDIT_W = 6
);
  logic [1:0]          cash_in;   // 00 none, 01 5tk, 10 10tk, 11 20tk
  logic                cancel;    // refund request
  logic                purchase;  // one-cycle vend pulse
  logic [1:0]          cash_ret;  // change chunk: 00 0, 01 5, 10 10, 11 15 tk
  logic                busy;      // change/refund being paid out
  logic                coin_rej;  // coin arrived while paying out
  logic [CREDIT_W-1:0] credit;    // accumulated credit in tk

  modport slave (
    input  cash_in, cancel,
    output purchase, cash_ret, busy, coin_rej, credit
  );

  modport master (
    output cash_in, cancel,
    input  purchase, cash_ret, busy, coin_rej, credit
  );
endinterface

// File: rtl/vm_multi_coin.sv
// Multi-coin vending controller. Accumulates 5/10/20 tk coins, vends when
// the credit reaches PRICE, and pays change or refunds in chunks of at most
// 15 tk, one chunk per clock. Every output is a register.
module vm_multi_coin #(
  parameter int PRICE    = 25,  // nonzero multiple of 5
  parameter int CREDIT_W = 6    // PRICE+20 must fit in CREDIT_W bits
) (
  input  logic            i_clk,
  input  logic            i_reset,   // asynchronous, active low
  vm_multi_coin_if.slave  io_bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    PAYOUT  = 1'b1
  } state_t;

  localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] LP_C5    = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] LP_C10   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] LP_C15   = CREDIT_W'(15);
  localparam logic [CREDIT_W-1:0] LP_C20   = CREDIT_W'(20);

  state_t              r_state,    w_state_n;
  logic [CREDIT_W-1:0] r_credit,   w_credit_n;
  logic [CREDIT_W-1:0] r_change,   w_change_n;
  logic                r_purchase, w_purchase_n;
  logic [1:0]          r_cash_ret, w_cash_ret_n;
  logic                r_busy,     w_busy_n;
  logic                r_coin_rej, w_coin_rej_n;

  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W-1:0] w_sum;
  logic [CREDIT_W-1:0] w_chunk;
  logic [1:0]          w_chunk_code;

  // Coin decode and the per-edge payout chunk (change is always a multiple of 5)
  always_comb begin
    w_coin_val = '0;
    case (io_bus.cash_in)
      2'b01:   w_coin_val = LP_C5;
      2'b10:   w_coin_val = LP_C10;
      2'b11:   w_coin_val = LP_C20;
      default: w_coin_val = '0;
    endcase
    w_sum = r_credit + w_coin_val;

    w_chunk      = (r_change >= LP_C15) ? LP_C15 : r_change;
    w_chunk_code = 2'b00;
    if (w_chunk == LP_C15)      w_chunk_code = 2'b11;
    else if (w_chunk == LP_C10) w_chunk_code = 2'b10;
    else if (w_chunk == LP_C5)  w_chunk_code = 2'b01;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_n    = r_state;
    w_credit_n   = r_credit;
    w_change_n   = r_change;
    w_purchase_n = 1'b0;
    w_cash_ret_n = 2'b00;
    w_coin_rej_n = 1'b0;

    case (r_state)
      COLLECT: begin
        if (io_bus.cancel) begin
          // Refund wins over a vend; the same-cycle coin is refunded too.
          w_credit_n = '0;
          w_change_n = w_sum;
          if (w_sum != '0) w_state_n = PAYOUT;
        end else if (w_sum >= LP_PRICE) begin
          w_purchase_n = 1'b1;
          w_credit_n   = '0;
          w_change_n   = w_sum - LP_PRICE;
          if (w_sum != LP_PRICE) w_state_n = PAYOUT;
        end else begin
          w_credit_n = w_sum;
        end
      end
      PAYOUT: begin
        // Coins are bounced and cancel is ignored while change is owed.
        w_coin_rej_n = (io_bus.cash_in != 2'b00);
        w_cash_ret_n = w_chunk_code;
        w_change_n   = r_change - w_chunk;
        if (w_change_n == '0) w_state_n = COLLECT;
      end
      default: w_state_n = COLLECT;
    endcase

    // busy covers the cycle a chunk is presented, including the last one.
    w_busy_n = (w_state_n == PAYOUT) || (r_state == PAYOUT);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= COLLECT;
      r_credit   <= '0;
      r_change   <= '0;
      r_purchase <= 1'b0;
      r_cash_ret <= 2'b00;
      r_busy     <= 1'b0;
      r_coin_rej <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_credit   <= w_credit_n;
      r_change   <= w_change_n;
      r_purchase <= w_purchase_n;
      r_cash_ret <= w_cash_ret_n;
      r_busy     <= w_busy_n;
      r_coin_rej <= w_coin_rej_n;
    end
  end

  assign io_bus.purchase = r_purchase;
  assign io_bus.cash_ret = r_cash_ret;
  assign io_bus.busy     = r_busy;
  assign io_bus.coin_rej = r_coin_rej;
  assign io_bus.credit   = r_credit;

endmodule

// File: tb/tb_vm_multi_coin.sv
// Bench for vm_multi_coin: directed scenarios then random coins/cancels with
// occasional asynchronous resets, checked against a queue-based model.
module tb_vm_multi_coin;

  localparam int PRICE    = 25;
  localparam int CREDIT_W = 6;

  logic gclk;
  logic grst_n;

  vm_multi_coin_if #(.CREDIT_W(CREDIT_W)) bus ();

  vm_multi_coin #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
    .i_clk   (gclk),
    .i_reset (grst_n),
    .io_bus  (bus)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: credit in tk plus a queue of change chunks still owed.
  int m_credit;
  int m_chunks[$];
  int e_pur, e_ret, e_busy, e_rej;

  function automatic int coin_tk(input int code);
    case (code)
      1: return 5;
      2: return 10;
      3: return 20;
      default: return 0;
    endcase
  endfunction

  task automatic m_owe(input int amount);
    int a = amount;
    while (a > 0) begin
      int k = (a > 15) ? 15 : a;
      m_chunks.push_back(k);
      a -= k;
    end
  endtask

  task automatic m_reset();
    m_credit = 0;
    m_chunks.delete();
    e_pur = 0; e_ret = 0; e_busy = 0; e_rej = 0;
  endtask

  task automatic m_edge(input int cash, input int cancel);
    int v = coin_tk(cash);
    e_pur = 0; e_ret = 0; e_rej = 0;
    if (m_chunks.size() > 0) begin
      e_ret  = m_chunks.pop_front() / 5;
      e_rej  = (v != 0);
      e_busy = 1;
    end else begin
      int sum = m_credit + v;
      if (cancel != 0) begin
        m_credit = 0;
        m_owe(sum);
      end else if (sum >= PRICE) begin
        e_pur    = 1;
        m_credit = 0;
        m_owe(sum - PRICE);
      end else begin
        m_credit = sum;
      end
      e_busy = (m_chunks.size() > 0);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".purchase"}, int'(bus.purchase), e_pur);
    chk({tag, ".cash_ret"}, int'(bus.cash_ret), e_ret);
    chk({tag, ".busy"},     int'(bus.busy),     e_busy);
    chk({tag, ".coin_rej"}, int'(bus.coin_rej), e_rej);
    chk({tag, ".credit"},   int'(bus.credit),   m_credit);
  endtask

  // One clock: drive at negedge, optional async reset pulse mid-cycle,
  // advance the model at posedge and compare 1 time unit later.
  task automatic step(input string tag, input int cash, input int cancel, input bit rst_pulse);
    @(negedge gclk);
    bus.cash_in = 2'(cash);
    bus.cancel  = cancel[0];
    if (rst_pulse) begin
      #1 grst_n = 1'b0;
      #1;
      m_reset();
      chk_all({tag, ".rst"});
      #1 grst_n = 1'b1;
    end
    @(posedge gclk);
    m_edge(cash, cancel);
    #1;
    chk_all(tag);
  endtask

  initial begin
    grst_n      = 1'b0;
    bus.cash_in = 2'b00;
    bus.cancel  = 1'b0;
    m_reset();
    #7;
    chk_all("reset");
    @(negedge gclk);
    grst_n = 1'b1;

    // 5, 10, 10 -> credit 5, 15, then exact vend
    step("r29a", 1, 0, 0); chk("r29a.credit_k", int'(bus.credit), 5);
    step("r29b", 2, 0, 0); chk("r29b.credit_k", int'(bus.credit), 15);
    step("r29c", 2, 0, 0); chk("r29c.purchase_k", int'(bus.purchase), 1);
    chk("r29c.busy_k", int'(bus.busy), 0);
    step("idle0", 0, 0, 0);

    // 20, 20 -> vend, one 15 chunk; a 5 coin during payout is rejected
    step("r30a", 3, 0, 0);
    step("r30b", 3, 0, 0); chk("r30b.purchase_k", int'(bus.purchase), 1);
    step("r33",  1, 0, 0); chk("r30c.cash_ret_k", int'(bus.cash_ret), 3);
    chk("r33.coin_rej_k", int'(bus.coin_rej), 1);
    chk("r30c.busy_k", int'(bus.busy), 1);
    step("r30d", 0, 0, 0); chk("r30d.busy_k", int'(bus.busy), 0);
    chk("r33.rej_clear_k", int'(bus.coin_rej), 0);

    // 20 then bare cancel -> 15 then 5 refunded
    step("r31a", 3, 0, 0);
    step("r31b", 0, 1, 0); chk("r31b.purchase_k", int'(bus.purchase), 0);
    step("r31c", 0, 0, 0); chk("r31c.cash_ret_k", int'(bus.cash_ret), 3);
    step("r31d", 0, 0, 0); chk("r31d.cash_ret_k", int'(bus.cash_ret), 1);
    step("r31e", 0, 0, 0); chk("r31e.cash_ret_k", int'(bus.cash_ret), 0);

    // 20 then 5 with cancel -> refund of 25 instead of a vend
    step("r32a", 3, 0, 0);
    step("r32b", 1, 1, 0); chk("r32b.purchase_k", int'(bus.purchase), 0);
    step("r32c", 0, 0, 0); chk("r32c.cash_ret_k", int'(bus.cash_ret), 3);
    step("r32d", 0, 0, 0); chk("r32d.cash_ret_k", int'(bus.cash_ret), 2);
    step("r32e", 0, 0, 0);

    // reset between the 15 and 5 chunks of a refund discards the rest
    step("r34a", 3, 0, 0);
    step("r34b", 0, 1, 0);
    step("r34c", 0, 0, 0);
    step("r34d", 0, 0, 1); chk("r34d.cash_ret_k", int'(bus.cash_ret), 0);
    step("r34e", 0, 0, 0); chk("r34e.cash_ret_k", int'(bus.cash_ret), 0);

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      int cash = int'($urandom_range(0, 3));
      int canc = ($urandom_range(0, 7) == 0) ? 1 : 0;
      bit rp   = ($urandom_range(0, 59) == 0);
      step($sformatf("rnd%0d", i), cash, canc, rp);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
